// File: rtl/brp_resolver.sv
// EX-stage branch resolver: compares the carried prediction with the ALU outcome, emits the
// resolved record for predictor training, and drives redirect/flush on a mispredict.
package brp_pkg;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] brp_alt;
    logic        predicted;
    logic        prediction;
    logic        mp_valid;
    logic        mispredicted;
  } rv32i_brp_word;
endpackage

module brp_resolver
  import brp_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          stall,
  input  rv32i_opcode   opcode_ex,
  input  rv32i_brp_word brp_ex_in,
  input  logic          br_en,
  output rv32i_brp_word brp_ex_out,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          flush,
  output logic          busy,
  output logic [CNT_W-1:0] c_total,
  output logic [CNT_W-1:0] c_mispred
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          fire, mp;

  // Only predicted conditional branches are resolved; anything seen during FLUSH is wrong-path.
  assign fire = ex_valid && !stall && (state == IDLE) &&
                (opcode_ex == op_br) && brp_ex_in.predicted;
  assign mp   = fire && (brp_ex_in.prediction != br_en);

  assign flush = (state == FLUSH);
  assign busy  = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (mp) begin
        state_n = FLUSH;
        cnt_n   = CW'(FLUSH_CYCLES - 1);
      end
      FLUSH: if (cnt == '0) state_n = IDLE;
             else           cnt_n   = cnt - CW'(1);
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      brp_ex_out     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      c_total        <= '0;
      c_mispred      <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      redirect_valid <= mp;
      brp_ex_out     <= '0;
      if (fire) begin
        brp_ex_out              <= brp_ex_in;
        brp_ex_out.mp_valid     <= 1'b1;
        brp_ex_out.mispredicted <= mp;
      end
      if (mp) redirect_pc <= brp_ex_in.brp_alt;
      // Saturating counters: never wrap back below the other counter.
      if (fire && !(&c_total))  c_total   <= c_total + CNT_W'(1);
      if (mp   && !(&c_mispred)) c_mispred <= c_mispred + CNT_W'(1);
    end
  end
endmodule
